// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;
  localparam int unsigned IF_PC_STEP   = 4;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {instruction, npc} holding register used while decode is stalled.
module if_skid_buffer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] npc_i,
  output logic        full_o,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o
);

  logic        full_q, full_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      npc_d   = npc_i;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      npc_q   <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, redirect drain and IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR,
  parameter int unsigned PC_STEP   = IF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_instruction,
  output logic [31:0] IFID_NPC,
  output logic        IFID_valid
);

  localparam logic [31:0] PcStep = 32'(PC_STEP);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_npc_q, ifid_npc_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  pc_next;
  logic         skid_load, skid_clear, skid_full;
  logic [31:0]  skid_instr, skid_npc;

  assign pc_next = pc_q + PcStep;

  if_skid_buffer u_skid (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .npc_i   (pc_next),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .npc_o   (skid_npc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    ifid_instr_d = ifid_instr_q;
    ifid_npc_d   = ifid_npc_q;
    ifid_valid_d = ifid_valid_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          if (imem_ack) begin
            pc_d = redirect_target;
          end else begin
            // Request is still owed a response; wait for it before refetching.
            tgt_d   = redirect_target;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_next;
          if (stall) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            ifid_instr_d = imem_rdata;
            ifid_npc_d   = pc_next;
            ifid_valid_d = 1'b1;
          end
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          skid_clear   = 1'b1;
          pc_d         = redirect_target;
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          state_d      = FETCH;
        end else if (!stall) begin
          skid_clear   = 1'b1;
          ifid_instr_d = skid_instr;
          ifid_npc_d   = skid_npc;
          ifid_valid_d = skid_full;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          tgt_d = redirect_target;
        end
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_target : tgt_q;
          state_d = FETCH;
        end
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_npc_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_npc_q   <= ifid_npc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_req         = rst_n && ((state_q == FETCH) || (state_q == DRAIN));
  assign imem_addr        = pc_q;
  assign IFID_instruction = ifid_instr_q;
  assign IFID_NPC         = ifid_npc_q;
  assign IFID_valid       = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench: accepted fetches are queued as expected decode entries, popped as decode consumes.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] IFID_instruction;
  logic [31:0] IFID_NPC;
  logic        IFID_valid;

  int tests = 0;
  int fails = 0;
  bit rand_data = 1'b0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_addr = '0;
  bit          owed = 1'b0;
  bit          last_free = 1'b1;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .IFID_instruction (IFID_instruction),
    .IFID_NPC         (IFID_NPC),
    .IFID_valid       (IFID_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model. Runs mid-cycle, so it sees the values the next posedge will use.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_req", {31'd0, imem_req}, 32'd0);
      check("reset_valid", {31'd0, IFID_valid}, 32'd0);
      check("reset_instr", IFID_instruction, 32'd0);
      sb_q.delete();
      exp_addr  = 32'h0;
      owed      = 1'b0;
      last_free = 1'b1;
      prev_wait = 1'b0;
    end else begin
      if (!IFID_valid) check("nop_when_invalid", IFID_instruction, 32'd0);
      if (last_free) check("valid_vs_pending", {31'd0, IFID_valid}, {31'd0, sb_q.size() != 0});
      if (prev_wait) begin
        check("req_held", {31'd0, imem_req}, 32'd1);
        check("addr_stable", imem_addr, prev_addr);
      end
      if (imem_req && !owed) check("fetch_addr", imem_addr, exp_addr);
      if (IFID_valid && !stall && !redirect_valid) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL consume_empty: got npc %h, expected no valid entry", IFID_NPC);
        end else begin
          e = sb_q.pop_front();
          check("ifid_instr", IFID_instruction, e.instr);
          check("ifid_npc", IFID_NPC, e.npc);
        end
      end
      if (redirect_valid) begin
        sb_q.delete();
        exp_addr = redirect_target;
        owed     = imem_req && !imem_ack;
      end else if (imem_req && imem_ack) begin
        if (owed) begin
          owed = 1'b0;
        end else begin
          e.instr = imem_rdata;
          e.npc   = exp_addr + 32'd4;
          sb_q.push_back(e);
          exp_addr = exp_addr + 32'd4;
        end
      end
      last_free = !stall || redirect_valid;
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic drive(input logic st, input logic rv, input logic [31:0] tgt, input logic ak);
    @(posedge clk);
    #1;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_ack        = imem_req & ak;
    imem_rdata      = rand_data ? $urandom() : (imem_addr ^ 32'hA5A5_0000);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_valid", {31'd0, IFID_valid}, 32'd0);
    check("async_instr", IFID_instruction, 32'd0);
    check("async_npc", IFID_NPC, 32'd0);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Sequential stream with a late ack on address 8.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Stall on the cycle address 16 acks, held for three cycles.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect while address 24 is outstanding.
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect with stall while in HOLD, to the wrap-around address.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    mid_reset();
    // Randomised traffic.
    rand_data = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else if ($urandom_range(0, 7) == 0) tgt = $urandom();
      else tgt = $urandom() & 32'h0000_FFFC;
      drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6, tgt,
            $urandom_range(0, 99) < 60);
      if ($urandom_range(0, 499) == 0) mid_reset();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
